// File: rtl/funct_generator_pkg.sv
// Shared types for the function generator segment sequencer.
// Table field widths track the default generator build.
package funct_generator_pkg;

  localparam int SEQ_AMP_W = 4;
  localparam int SEQ_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONF,
    ST_RUN
  } seq_state_t;

  localparam logic [1:0] SEL_SIN = 2'd0;
  localparam logic [1:0] SEL_COS = 2'd1;
  localparam logic [1:0] SEL_TRI = 2'd2;
  localparam logic [1:0] SEL_SQU = 2'd3;

  typedef struct packed {
    logic [1:0]           sel;
    logic [SEQ_AMP_W-1:0] amp;
    logic [SEQ_LEN_W-1:0] len;
  } seg_t;

endpackage

// File: rtl/funct_generator_sequencer_if.sv
// Control, table-write and generator-drive bundle of the sequencer.
// FUNCT_SEQ_LOOP_EN adds the loop_i control.
interface funct_generator_sequencer_if #(
  parameter int INT_BITS = 4,
  parameter int NUM_SEG  = 4,
  parameter int LEN_W    = 16
);
  localparam int SEG_W = $clog2(NUM_SEG);

  logic                start_i;
  logic                abort_i;
  logic                fifo_afull_i;
  logic                seg_wr_i;
  logic [SEG_W-1:0]    seg_idx_i;
  logic [1:0]          seg_sel_i;
  logic [INT_BITS-1:0] seg_amp_i;
  logic [LEN_W-1:0]    seg_len_i;
  logic [SEG_W-1:0]    seg_last_i;
`ifdef FUNCT_SEQ_LOOP_EN
  logic                loop_i;
`endif
  logic                gen_en_n_o;
  logic                gen_conf_o;
  logic [INT_BITS-1:0] amp_o;
  logic [1:0]          sel_o;
  logic                busy_o;
  logic [SEG_W-1:0]    cur_seg_o;
  logic                seg_done_o;
  logic                done_o;

  modport master (
`ifdef FUNCT_SEQ_LOOP_EN
    output loop_i,
`endif
    output start_i, abort_i, fifo_afull_i,
    output seg_wr_i, seg_idx_i, seg_sel_i,
    output seg_amp_i, seg_len_i, seg_last_i,
    input  gen_en_n_o, gen_conf_o, amp_o, sel_o,
    input  busy_o, cur_seg_o, seg_done_o, done_o
  );

  modport slave (
`ifdef FUNCT_SEQ_LOOP_EN
    input  loop_i,
`endif
    input  start_i, abort_i, fifo_afull_i,
    input  seg_wr_i, seg_idx_i, seg_sel_i,
    input  seg_amp_i, seg_len_i, seg_last_i,
    output gen_en_n_o, gen_conf_o, amp_o, sel_o,
    output busy_o, cur_seg_o, seg_done_o, done_o
  );
endinterface

// File: rtl/funct_generator_seg_table.sv
// Segment table: NUM_SEG entries, one write port,
// one combinational read port, async reset to all-zero.
module funct_generator_seg_table
  import funct_generator_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int SEG_W   = $clog2(NUM_SEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [SEG_W-1:0] i_widx,
  input  seg_t             i_wdata,
  input  logic [SEG_W-1:0] i_ridx,
  output seg_t             o_rdata
);

  seg_t r_mem [NUM_SEG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/funct_generator_sequencer.sv
// Segment sequencer: configures the generator, then enables it len cycles.
// FUNCT_SEQ_LOOP_EN: wrap to segment 0 while loop_i is high.
module funct_generator_sequencer
  import funct_generator_pkg::*;
#(
  parameter int INT_BITS = SEQ_AMP_W,
  parameter int NUM_SEG  = 4,
  parameter int LEN_W    = SEQ_LEN_W
) (
  input logic clk,
  input logic rst,
  funct_generator_sequencer_if.slave bus
);

  localparam int SEG_W = $clog2(NUM_SEG);

  seq_state_t          r_state, w_state;
  logic [LEN_W-1:0]    r_iss, w_iss;
  logic [LEN_W-1:0]    r_len, w_len;
  logic [SEG_W-1:0]    r_cur, w_cur;
  logic [SEG_W-1:0]    r_last, w_last;
  logic [SEG_W-1:0]    w_nxt, w_rd_idx, w_last_in;
  logic                r_en_n, w_en_n;
  logic                r_conf, w_conf;
  logic                r_busy, w_busy;
  logic                r_sd, w_sd;
  logic                r_done, w_done;
  logic [INT_BITS-1:0] r_amp, w_amp;
  logic [1:0]          r_sel, w_sel;
  logic                w_enter, w_loop, w_we;
  logic [LEN_W-1:0]    w_rd_len;
  seg_t                w_wdata, w_rd;

`ifdef FUNCT_SEQ_LOOP_EN
  assign w_loop = bus.loop_i;
`else
  assign w_loop = 1'b0;
`endif

  assign w_we    = bus.seg_wr_i && (r_state == ST_IDLE);
  assign w_wdata = '{sel: bus.seg_sel_i,
                     amp: SEQ_AMP_W'(bus.seg_amp_i),
                     len: SEQ_LEN_W'(bus.seg_len_i)};

  assign w_last_in = (32'(bus.seg_last_i) >= NUM_SEG) ?
                     SEG_W'(NUM_SEG - 1) : bus.seg_last_i;
  // Entry to load next: seg 0 on start or wrap, else the following one
  assign w_nxt    = (r_cur == r_last) ? '0 : r_cur + 1'b1;
  assign w_rd_idx = (r_state == ST_IDLE) ? '0 : w_nxt;
  assign w_rd_len = LEN_W'(w_rd.len);

  funct_generator_seg_table #(
    .NUM_SEG (NUM_SEG),
    .SEG_W   (SEG_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_widx  (bus.seg_idx_i),
    .i_wdata (w_wdata),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rd)
  );

  always_comb begin
    w_state = r_state;
    w_iss   = r_iss;
    w_len   = r_len;
    w_cur   = r_cur;
    w_last  = r_last;
    w_en_n  = 1'b1;
    w_conf  = 1'b0;
    w_amp   = r_amp;
    w_sel   = r_sel;
    w_sd    = 1'b0;
    w_done  = 1'b0;
    w_enter = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_last  = w_last_in;
          w_enter = 1'b1;
        end
      end
      ST_CONF: begin
        w_state = bus.abort_i ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort_i) begin
          w_state = ST_IDLE;
        end else if (r_iss == r_len) begin
          w_sd   = 1'b1;
          w_iss  = '0;
          w_done = (r_cur == r_last);
          if ((r_cur != r_last) || w_loop) w_enter = 1'b1;
          else                             w_state = ST_IDLE;
        end else if (!bus.fifo_afull_i) begin
          w_en_n = 1'b0;
          w_iss  = r_iss + 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    if (w_state == ST_IDLE) begin
      w_iss = '0;
      w_cur = '0;
    end
    // Zero-length entries bypass CONF and spend a single RUN cycle
    if (w_enter) begin
      w_cur = w_rd_idx;
      w_len = w_rd_len;
      w_iss = '0;
      if (w_rd_len == '0) begin
        w_state = ST_RUN;
      end else begin
        w_state = ST_CONF;
        w_conf  = 1'b1;
        w_amp   = INT_BITS'(w_rd.amp);
        w_sel   = w_rd.sel;
      end
    end
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_iss   <= '0;
      r_len   <= '0;
      r_cur   <= '0;
      r_last  <= '0;
      r_en_n  <= 1'b1;
      r_conf  <= 1'b0;
      r_amp   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_sd    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_iss   <= w_iss;
      r_len   <= w_len;
      r_cur   <= w_cur;
      r_last  <= w_last;
      r_en_n  <= w_en_n;
      r_conf  <= w_conf;
      r_amp   <= w_amp;
      r_sel   <= w_sel;
      r_busy  <= w_busy;
      r_sd    <= w_sd;
      r_done  <= w_done;
    end
  end

  assign bus.gen_en_n_o = r_en_n;
  assign bus.gen_conf_o = r_conf;
  assign bus.amp_o      = r_amp;
  assign bus.sel_o      = r_sel;
  assign bus.busy_o     = r_busy;
  assign bus.cur_seg_o  = r_cur;
  assign bus.seg_done_o = r_sd;
  assign bus.done_o     = r_done;

endmodule

// File: doc/funct_generator_sequencer.md
# funct_generator_sequencer

Segment sequencer for the function generator datapath. It holds a small table of waveform segments, each with a selector, an amplitude and a sample count. On start it plays the segments in order. For each segment it loads sel/amp through the generator's configuration strobe, then enables generation for exactly the programmed number of cycles, and it throttles generation on FIFO almost-full. It sits between the host/control logic and the generator's `en_low_i`, `enh_conf_i`, `amp_i` and `sel_i` inputs.

## Interface
- `INT_BITS`, default 4: amplitude integer width; matches the generator.
- `NUM_SEG`, default 4: number of segment table entries.
- `LEN_W`, default 16: segment length counter width.
- `SEG_W`, localparam `$clog2(NUM_SEG)`: segment index width.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start_i`  in  1  starts playback; accepted only in IDLE.
- `abort_i`  in  1  stops playback and returns to IDLE.
- `fifo_afull_i`  in  1  downstream FIFO almost-full; pauses generation.
- `seg_wr_i`  in  1  table write strobe; accepted only in IDLE.
- `seg_idx_i`  in  SEG_W  table write index.
- `seg_sel_i`  in  2  waveform select: 0 sin, 1 cos, 2 triangular, 3 square.
- `seg_amp_i`  in  INT_BITS  signed amplitude.
- `seg_len_i`  in  LEN_W  samples in the segment; 0 means skip.
- `seg_last_i`  in  SEG_W  index of the last segment to play; sampled at start.
- `gen_en_n_o`  out  1  generator enable, active-low; drives `en_low_i`.
- `gen_conf_o`  out  1  one-cycle configuration strobe; drives `enh_conf_i`.
- `amp_o`  out  INT_BITS  amplitude for the generator.
- `sel_o`  out  2  waveform select for the generator.
- `busy_o`  out  1  high when the state is not IDLE.
- `cur_seg_o`  out  SEG_W  index of the segment being played.
- `seg_done_o`  out  1  one-cycle pulse after a segment's last enable cycle.
- `done_o`  out  1  one-cycle pulse when playback completes.

## Operation
- FSM states:
  - IDLE: start_i goes to CONF with segment 0; abort_i has no effect.
  - CONF: one cycle. `gen_conf_o` is 1, and `amp_o`/`sel_o` hold the current entry. Next state is RUN.
  - RUN: on each edge where `iss < len` and `fifo_afull_i` is 0, `gen_en_n_o` is registered to 0 and `iss` increments. Otherwise `gen_en_n_o` is registered to 1.
  - End of RUN: when `iss == len` in RUN, the block pulses `seg_done_o`, clears `iss`, and moves to the next segment's CONF. After segment `seg_last_i` it moves to IDLE and pulses `done_o`.
- Result: exactly `len` low cycles of `gen_en_n_o` per segment, independent of pauses.
- Zero-length segment: CONF is skipped. `seg_done_o` pulses and the sequencer advances directly, spending one cycle in RUN.
- `seg_last_i >= NUM_SEG`: clamped to NUM_SEG-1.
- `abort_i` in CONF or RUN: next edge goes to IDLE, `gen_en_n_o`=1, `gen_conf_o`=0, `iss` and `cur_seg_o` cleared, no `done_o`. abort_i has priority over start_i.
- `start_i` while busy is ignored. `seg_wr_i` while busy is ignored, and the table is unchanged.
- Amplitude 0 or most-negative is passed through unchanged; the generator keeps its previous amplitude in that case.
- `amp_o`/`sel_o` hold their value after CONF until the next CONF.
- Reset values:
  - `gen_en_n_o`=1.
  - All other outputs 0.
  - State IDLE, `iss`=0.
  - Table entries all-zero, so len=0.

## Timing
- All outputs are registered.
- `start_i` high in cycle T:
  - `gen_conf_o` high in T+1.
  - RUN in T+2.
  - `gen_en_n_o` low in T+3 … T+2+len, with no almost-full.
  - `seg_done_o` and the next segment's `gen_conf_o` in T+3+len.
- Gap between segments: 2 cycles of `gen_en_n_o`=1.
- Almost-full reaction: 1 cycle. `fifo_afull_i` sampled high at edge E gives `gen_en_n_o`=1 from E+1. The FIFO must assert almost-full with at least (1 + generator latency) free entries.
- A table write in cycle T is visible to a start in T+1.

## Configuration
- `FUNCT_SEQ_LOOP_EN` defined:
  - Adds input `loop_i` (1 bit).
  - If `loop_i` is 1 when the last segment ends, playback wraps to segment 0's CONF and `done_o` pulses at each wrap.
  - `busy_o` stays high; only `abort_i` or `loop_i`=0 at wrap time ends playback.
- `FUNCT_SEQ_LOOP_EN` undefined: no `loop_i` port; the last segment always goes to IDLE.

## Structure
- `funct_generator_pkg` contains:
  - the state enum `seq_state_t`;
  - the packed struct `seg_t` with fields `sel`, `amp`, `len`;
  - the waveform select constants `SEL_SIN`, `SEL_COS`, `SEL_TRI`, `SEL_SQU`.
- Sub-module `funct_generator_seg_table`: NUM_SEG×`seg_t` register file with async reset, one write port and one combinational read port.

## Test plan
- Single segment: seg0 = {sel 2, amp 3, len 5}, seg_last 0, start → `gen_conf_o` in T+1 with amp_o=3 and sel_o=2; `gen_en_n_o` low for exactly 5 cycles from T+3; `seg_done_o` and `done_o` in T+8.
- Three segments: lens 4/0/6, seg_last 2 → 4 and 6 enable cycles; segment 1 produces only a `seg_done_o` pulse with no `gen_conf_o`; `cur_seg_o` steps 0→1→2.
- Backpressure: len 10, `fifo_afull_i` high for 3 cycles mid-RUN → `gen_en_n_o` high for exactly 3 cycles, offset by one cycle; still 10 low cycles in total.
- Abort mid-RUN after 2 enable cycles → IDLE next edge, `gen_en_n_o`=1, no `done_o`; a new start replays from segment 0 with the full length.
- Busy-time writes and start: `seg_wr_i` and `start_i` during RUN → table unchanged and no restart; async `rst` mid-RUN → all outputs at reset values immediately.
- With `FUNCT_SEQ_LOOP_EN`: `loop_i`=1, two segments → `done_o` pulses at each wrap while `busy_o` stays 1; dropping `loop_i` before the last segment ends → IDLE.
